// File: rtl/responder_ctrl.sv
// Quiz responder control: arms a round, counts down per second, latches the first
// key to rise and raises one buzzer request for BUZZ_CYCLES. All outputs registered.
module responder_ctrl #(
  parameter int TICK_CYCLES = 50000000,
  parameter int ANSWER_TIME = 20,
  parameter int BUZZ_CYCLES = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Host_Start,
  input  logic       Host_Clear,
  input  logic [3:0] Key_In,
  output logic [3:0] Winner,
  output logic [4:0] Time_Left,
  output logic       Armed,
  output logic       Buzzer_Answer,
  output logic       Buzzer_TimeOver
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);
  localparam logic [4:0]    TIME_INIT = 5'(ANSWER_TIME);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TIMEOUT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    key_prev_q;
  logic [3:0]    rise, first_rise;
  logic [3:0]    winner_q, winner_d;
  logic [4:0]    time_q, time_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] buzz_q, buzz_d;
  logic          armed_q, armed_d;
  logic          ans_q, ans_d;
  logic          to_q, to_d;

  assign rise = Key_In & ~key_prev_q;

  // Simultaneous presses resolve to the lowest player number.
  always_comb begin
    first_rise = 4'b0000;
    if (rise[0])      first_rise = 4'b0001;
    else if (rise[1]) first_rise = 4'b0010;
    else if (rise[2]) first_rise = 4'b0100;
    else if (rise[3]) first_rise = 4'b1000;
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    time_d   = time_q;
    tick_d   = tick_q;
    buzz_d   = buzz_q;
    ans_d    = ans_q;
    to_d     = to_q;
    if (Host_Clear) begin
      state_d  = IDLE;
      winner_d = 4'b0000;
      time_d   = 5'd0;
      tick_d   = '0;
      buzz_d   = '0;
      ans_d    = 1'b0;
      to_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Host_Start) begin
            state_d  = ARMED;
            time_d   = TIME_INIT;
            tick_d   = '0;
            winner_d = 4'b0000;
          end
        end
        ARMED: begin
          tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
          // A key rise beats a final decrement on the same edge.
          if (|rise) begin
            state_d  = LOCKED;
            winner_d = first_rise;
            ans_d    = 1'b1;
            buzz_d   = '0;
          end else if (tick_q == TICK_LAST && time_q != 5'd0) begin
            time_d = time_q - 5'd1;
            if (time_q == 5'd1) begin
              state_d = TIMEOUT;
              to_d    = 1'b1;
              buzz_d  = '0;
            end
          end
        end
        LOCKED, TIMEOUT: begin
          if (ans_q || to_q) begin
            if (buzz_q == BUZZ_LAST) begin
              ans_d = 1'b0;
              to_d  = 1'b0;
            end else begin
              buzz_d = buzz_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      key_prev_q <= 4'hF;
      winner_q   <= 4'b0000;
      time_q     <= 5'd0;
      tick_q     <= '0;
      buzz_q     <= '0;
      armed_q    <= 1'b0;
      ans_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= Key_In;
      winner_q   <= winner_d;
      time_q     <= time_d;
      tick_q     <= tick_d;
      buzz_q     <= buzz_d;
      armed_q    <= armed_d;
      ans_q      <= ans_d;
      to_q       <= to_d;
    end
  end

  assign Winner          = winner_q;
  assign Time_Left       = time_q;
  assign Armed           = armed_q;
  assign Buzzer_Answer   = ans_q;
  assign Buzzer_TimeOver = to_q;

endmodule

// File: tb/tb_responder_ctrl.sv
// Bench for responder_ctrl: directed scenarios plus a randomized run against a
// round-level model (elapsed-cycle arithmetic rather than counters).
module tb_responder_ctrl;

  localparam int TICK = 10;
  localparam int AT   = 3;
  localparam int BUZZ = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Host_Start = 1'b0;
  logic       Host_Clear = 1'b0;
  logic [3:0] Key_In = 4'b0000;
  logic [3:0] Winner;
  logic [4:0] Time_Left;
  logic       Armed, Buzzer_Answer, Buzzer_TimeOver;

  int checks = 0;
  int errors = 0;

  responder_ctrl #(.TICK_CYCLES(TICK), .ANSWER_TIME(AT), .BUZZ_CYCLES(BUZZ)) dut (
    .CLK(CLK), .RST(RST), .Host_Start(Host_Start), .Host_Clear(Host_Clear),
    .Key_In(Key_In), .Winner(Winner), .Time_Left(Time_Left), .Armed(Armed),
    .Buzzer_Answer(Buzzer_Answer), .Buzzer_TimeOver(Buzzer_TimeOver)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Round model: mode 0 idle, 1 armed, 2 answered, 3 timed out.
  int         m_mode = 0;
  int         m_elapsed = 0;
  int         m_buzz = 0;
  logic [3:0] m_winner = 4'b0000;
  logic [4:0] m_time = 5'd0;
  logic [3:0] m_prev = 4'hF;

  task automatic model_step();
    logic [3:0] r;
    int         t;
    r = Key_In & ~m_prev;
    m_prev = Key_In;
    if (RST) begin
      m_mode = 0; m_winner = 0; m_time = 0; m_buzz = 0; m_elapsed = 0; m_prev = 4'hF;
    end else if (Host_Clear) begin
      m_mode = 0; m_winner = 0; m_time = 0; m_buzz = 0;
    end else if (m_mode == 0) begin
      if (Host_Start) begin
        m_mode = 1; m_elapsed = 0; m_time = 5'(AT); m_winner = 0;
      end
    end else if (m_mode == 1) begin
      m_elapsed++;
      t = AT - m_elapsed / TICK;
      if (r != 0) begin
        m_mode = 2; m_winner = r & (~r + 4'd1); m_buzz = BUZZ;
      end else begin
        m_time = 5'(t);
        if (t == 0) begin
          m_mode = 3; m_buzz = BUZZ;
        end
      end
    end else if (m_buzz > 0) begin
      m_buzz--;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic clear_round();
    Host_Clear = 1'b1; tick(); Host_Clear = 1'b0;
  endtask

  task automatic start_round();
    Host_Start = 1'b1; tick(); Host_Start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    checks++;
    if ({Winner, Time_Left} !== 9'd0) begin
      errors++; $display("FAIL reset_regs: got %h/%0d want 0/0", Winner, Time_Left);
    end
    checks++;
    if ({Armed, Buzzer_Answer, Buzzer_TimeOver} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {Armed, Buzzer_Answer, Buzzer_TimeOver});
    end
  endtask

  task automatic test_answer();
    int cnt;
    start_round();
    checks++;
    if (Armed !== 1'b1 || Time_Left !== 5'd3) begin
      errors++; $display("FAIL arm: got armed=%b time=%0d want 1/3", Armed, Time_Left);
    end
    repeat (5) tick();
    Key_In = 4'b0100; tick();
    checks++;
    if (Winner !== 4'b0100 || Time_Left !== 5'd3 || Armed !== 1'b0 || Buzzer_Answer !== 1'b1) begin
      errors++; $display("FAIL answer_lock: got w=%b t=%0d a=%b ba=%b want 0100/3/0/1",
                         Winner, Time_Left, Armed, Buzzer_Answer);
    end
    cnt = 1;
    Key_In = 4'b0000;
    repeat (8) begin tick(); cnt += int'(Buzzer_Answer); end
    checks++;
    if (cnt != BUZZ) begin
      errors++; $display("FAIL answer_buzz_len: got %0d want %0d", cnt, BUZZ);
    end
    Key_In = 4'b0001; tick(); Key_In = 4'b0000; tick();
    checks++;
    if (Winner !== 4'b0100) begin
      errors++; $display("FAIL late_press: got %b want 0100", Winner);
    end
    clear_round();
  endtask

  task automatic test_timeout();
    int cnt;
    start_round();
    for (int s = AT - 1; s >= 0; s--) begin
      repeat (TICK - 1) tick();
      checks++;
      if (Time_Left !== 5'(s + 1) || Buzzer_TimeOver !== 1'b0) begin
        errors++; $display("FAIL countdown_hold: got t=%0d bt=%b want %0d/0", Time_Left, Buzzer_TimeOver, s + 1);
      end
      tick();
      checks++;
      if (Time_Left !== 5'(s)) begin
        errors++; $display("FAIL countdown_step: got %0d want %0d", Time_Left, s);
      end
    end
    checks++;
    if (Buzzer_TimeOver !== 1'b1 || Winner !== 4'b0000 || Armed !== 1'b0 || Buzzer_Answer !== 1'b0) begin
      errors++; $display("FAIL timeout_state: got bt=%b w=%b a=%b ba=%b want 1/0000/0/0",
                         Buzzer_TimeOver, Winner, Armed, Buzzer_Answer);
    end
    cnt = 1;
    repeat (8) begin tick(); cnt += int'(Buzzer_TimeOver); end
    checks++;
    if (cnt != BUZZ) begin
      errors++; $display("FAIL timeout_buzz_len: got %0d want %0d", cnt, BUZZ);
    end
    clear_round();
  endtask

  task automatic test_simultaneous();
    start_round();
    repeat (2) tick();
    Key_In = 4'b1010; tick();
    checks++;
    if (Winner !== 4'b0010) begin
      errors++; $display("FAIL simultaneous: got %b want 0010", Winner);
    end
    Key_In = 4'b0000;
    clear_round();
  endtask

  task automatic test_held_key();
    Key_In = 4'b0001; tick();
    start_round();
    repeat (3) tick();
    checks++;
    if (Armed !== 1'b1 || Winner !== 4'b0000) begin
      errors++; $display("FAIL held_key: got a=%b w=%b want 1/0000", Armed, Winner);
    end
    Key_In = 4'b0000; tick();
    Key_In = 4'b0001; tick();
    checks++;
    if (Winner !== 4'b0001 || Buzzer_Answer !== 1'b1) begin
      errors++; $display("FAIL repress: got w=%b ba=%b want 0001/1", Winner, Buzzer_Answer);
    end
    Key_In = 4'b0000;
    clear_round();
  endtask

  task automatic test_final_tick_tie();
    int bt;
    start_round();
    repeat (AT * TICK - 1) tick();
    Key_In = 4'b1000; tick();
    checks++;
    if (Winner !== 4'b1000 || Buzzer_Answer !== 1'b1 || Buzzer_TimeOver !== 1'b0 || Time_Left !== 5'd1) begin
      errors++; $display("FAIL tie: got w=%b ba=%b bt=%b t=%0d want 1000/1/0/1",
                         Winner, Buzzer_Answer, Buzzer_TimeOver, Time_Left);
    end
    bt = 0;
    repeat (6) begin tick(); bt += int'(Buzzer_TimeOver); end
    checks++;
    if (bt != 0 || Time_Left !== 5'd1) begin
      errors++; $display("FAIL tie_after: got bt_cycles=%0d t=%0d want 0/1", bt, Time_Left);
    end
    Key_In = 4'b0000;
    clear_round();
  endtask

  task automatic test_clear_and_reset();
    start_round();
    tick();
    Key_In = 4'b0100; tick(); tick();
    checks++;
    if (Buzzer_Answer !== 1'b1) begin
      errors++; $display("FAIL buzz_cycle2: got %b want 1", Buzzer_Answer);
    end
    Host_Clear = 1'b1; tick(); Host_Clear = 1'b0;
    checks++;
    if ({Buzzer_Answer, Armed, Winner, Time_Left} !== 11'd0) begin
      errors++; $display("FAIL clear_midbuzz: got ba=%b a=%b w=%b t=%0d want all 0",
                         Buzzer_Answer, Armed, Winner, Time_Left);
    end
    Key_In = 4'b0000;
    Host_Clear = 1'b1; Host_Start = 1'b1; tick(); Host_Clear = 1'b0; Host_Start = 1'b0;
    checks++;
    if (Armed !== 1'b0 || Time_Left !== 5'd0) begin
      errors++; $display("FAIL clear_beats_start: got a=%b t=%0d want 0/0", Armed, Time_Left);
    end
    start_round();
    checks++;
    if (Armed !== 1'b1 || Time_Left !== 5'd3) begin
      errors++; $display("FAIL rearm: got a=%b t=%0d want 1/3", Armed, Time_Left);
    end
    Key_In = 4'b0010; tick(); tick();
    RST = 1'b1; tick(); RST = 1'b0;
    checks++;
    if ({Buzzer_Answer, Buzzer_TimeOver, Armed, Winner, Time_Left} !== 12'd0) begin
      errors++; $display("FAIL reset_midbuzz: got ba=%b a=%b w=%b t=%0d want all 0",
                         Buzzer_Answer, Armed, Winner, Time_Left);
    end
    Key_In = 4'b0000; tick();
    start_round();
    Key_In = 4'b1000; tick();
    checks++;
    if (Winner !== 4'b1000 || Buzzer_Answer !== 1'b1) begin
      errors++; $display("FAIL post_reset_round: got w=%b ba=%b want 1000/1", Winner, Buzzer_Answer);
    end
    Key_In = 4'b0000;
    clear_round();
  endtask

  task automatic test_random();
    logic [11:0] obs, exp;
    for (int c = 0; c < 2000; c++) begin
      RST        = ($urandom_range(0, 399) == 0);
      Host_Clear = ($urandom_range(0, 59) == 0);
      Host_Start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 24) == 0) Key_In = 4'($urandom);
      tick();
      obs = {Winner, Time_Left, Armed, Buzzer_Answer, Buzzer_TimeOver};
      exp = {m_winner, m_time, m_mode == 1, m_mode == 2 && m_buzz > 0, m_mode == 3 && m_buzz > 0};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL random_cycle %0d: got w=%b t=%0d a/ba/bt=%b want w=%b t=%0d a/ba/bt=%b",
                           c, obs[11:8], obs[7:3], obs[2:0], exp[11:8], exp[7:3], exp[2:0]);
      end
      checks++;
      if (Buzzer_Answer && Buzzer_TimeOver) begin
        errors++; $display("FAIL buzz_exclusive %0d: got both high want at most one", c);
      end
    end
    RST = 1'b0; Host_Clear = 1'b0; Host_Start = 1'b0; Key_In = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_answer();
    test_timeout();
    test_simultaneous();
    test_held_key();
    test_final_tick_tie();
    test_clear_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
